// File: rtl/regfile_sb_param.sv
// Decode-stage register file with a per-register busy scoreboard.
// Register 0 is hard-wired to zero. There are two combinational read ports and
// one synchronous write port. An optional bypass forwards write data to reads
// of the same register in the same cycle. BusyCount tracks the number of
// registers that still wait for a multi-cycle producer.
module regfile_sb_param #(
    parameter int          WIDTH   = 32,
    parameter int          DEPTH   = 32,
    parameter int          BYPASS  = 1,
    parameter int          GP_IDX  = 28,
    parameter int unsigned GP_INIT = 32'h0000_1800,
    parameter int          SP_IDX  = 29,
    parameter int unsigned SP_INIT = 32'h0000_3ffc,
    localparam int         ADDR_W  = $clog2(DEPTH)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [ADDR_W-1:0]      ReadRegister1,
    input  logic [ADDR_W-1:0]      ReadRegister2,
    output logic [WIDTH-1:0]       ReadData1,
    output logic [WIDTH-1:0]       ReadData2,
    output logic                   ReadBusy1,
    output logic                   ReadBusy2,
    input  logic [ADDR_W-1:0]      WriteRegister,
    input  logic [WIDTH-1:0]       WriteData,
    input  logic                   RegWrite,
    input  logic [ADDR_W-1:0]      ReserveRegister,
    input  logic                   ReserveEn,
    output logic [ADDR_W:0]        BusyCount,
    output logic [DEPTH*WIDTH-1:0] AllOutputs
);

    localparam bit BYP_EN = (BYPASS != 0);

    logic [WIDTH-1:0]  regs_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_next_s;
    logic [ADDR_W:0]   busy_count_r;
    logic              wr_en_s;
    logic              rsv_en_s;
    logic              cnt_inc_s;
    logic              cnt_dec_s;
    logic              byp1_s;
    logic              byp2_s;

    // Reset contents: only the global and stack pointers start non-zero.
    function automatic logic [WIDTH-1:0] reset_value(input int idx);
        if (idx == GP_IDX) begin
            return WIDTH'(GP_INIT);
        end else if (idx == SP_IDX) begin
            return WIDTH'(SP_INIT);
        end else begin
            return {WIDTH{1'b0}};
        end
    endfunction

    // Writes and reserves that target register 0 are dropped here, so that
    // register 0 can never change and can never become busy.
    assign wr_en_s  = RegWrite  && (WriteRegister   != {ADDR_W{1'b0}});
    assign rsv_en_s = ReserveEn && (ReserveRegister != {ADDR_W{1'b0}});

    // The count rises only when a reserve hits an idle register. It falls only
    // when a write retires a busy register that is not being re-reserved in
    // the same cycle.
    assign cnt_inc_s = rsv_en_s && !busy_r[ReserveRegister];
    assign cnt_dec_s = wr_en_s && busy_r[WriteRegister]
                       && !(rsv_en_s && (ReserveRegister == WriteRegister));

    // Register array: preset on reset, otherwise written by the write port.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= reset_value(i);
            end
        end else if (wr_en_s) begin
            regs_r[WriteRegister] <= WriteData;
        end
    end

    // Next busy vector: a new reservation takes priority over a retiring write.
    always_comb begin
        busy_next_s = busy_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (rsv_en_s && (ReserveRegister == ADDR_W'(i))) begin
                busy_next_s[i] = 1'b1;
            end else if (wr_en_s && (WriteRegister == ADDR_W'(i))) begin
                busy_next_s[i] = 1'b0;
            end else begin
                busy_next_s[i] = busy_r[i];
            end
        end
    end

    // Scoreboard state and the incrementally maintained busy count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_r       <= {DEPTH{1'b0}};
            busy_count_r <= {(ADDR_W+1){1'b0}};
        end else begin
            busy_r       <= busy_next_s;
            busy_count_r <= busy_count_r + {{ADDR_W{1'b0}}, cnt_inc_s}
                                         - {{ADDR_W{1'b0}}, cnt_dec_s};
        end
    end

    // A same-cycle write to the addressed register overrides the stored value
    // and the stored busy bit when forwarding is enabled.
    always_comb begin
        byp1_s    = BYP_EN && !Reset && wr_en_s && (WriteRegister == ReadRegister1);
        byp2_s    = BYP_EN && !Reset && wr_en_s && (WriteRegister == ReadRegister2);
        ReadData1 = regs_r[ReadRegister1];
        ReadBusy1 = busy_r[ReadRegister1];
        ReadData2 = regs_r[ReadRegister2];
        ReadBusy2 = busy_r[ReadRegister2];
        if (byp1_s) begin
            ReadData1 = WriteData;
            ReadBusy1 = 1'b0;
        end else begin
            ReadData1 = regs_r[ReadRegister1];
            ReadBusy1 = busy_r[ReadRegister1];
        end
        if (byp2_s) begin
            ReadData2 = WriteData;
            ReadBusy2 = 1'b0;
        end else begin
            ReadData2 = regs_r[ReadRegister2];
            ReadBusy2 = busy_r[ReadRegister2];
        end
    end

    assign BusyCount = busy_count_r;

    // The debug snapshot shows stored state only and never shows forwarded data.
    for (genvar g = 0; g < DEPTH; g++) begin : g_snap
        assign AllOutputs[g*WIDTH +: WIDTH] = regs_r[g];
    end

endmodule

// File: tb/tb_regfile_sb_param.sv
// Directed bench for regfile_sb_param.
// The bench checks three instances: a 32x32 instance with bypass, a 32x32
// instance without bypass, and a 16x16 instance. Both 32-entry instances are
// checked every cycle against an array model of the architectural state. The
// model counts busy registers with a population count, not incrementally.
module tb_regfile_sb_param;

    logic        clk;
    logic        rst;
    logic [4:0]  r1, r2, wa, ra;
    logic [31:0] wd;
    logic        we, re;

    logic [31:0]   rd1, rd2, rd1_nb, rd2_nb;
    logic          b1, b2, b1_nb, b2_nb;
    logic [5:0]    cnt, cnt_nb;
    logic [1023:0] all_o, all_nb;

    logic [3:0]   r1_16, r2_16, wa16, ra16;
    logic [15:0]  wd16, rd1_16, rd2_16;
    logic         we16, re16, b1_16, b2_16;
    logic [4:0]   cnt16;
    logic [255:0] all16;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_reg  [32];
    logic        m_busy [32];

    regfile_sb_param #(.BYPASS(1)) dut (
        .Clk(clk), .Reset(rst), .ReadRegister1(r1), .ReadRegister2(r2),
        .ReadData1(rd1), .ReadData2(rd2), .ReadBusy1(b1), .ReadBusy2(b2),
        .WriteRegister(wa), .WriteData(wd), .RegWrite(we),
        .ReserveRegister(ra), .ReserveEn(re), .BusyCount(cnt), .AllOutputs(all_o));

    regfile_sb_param #(.BYPASS(0)) dut_nb (
        .Clk(clk), .Reset(rst), .ReadRegister1(r1), .ReadRegister2(r2),
        .ReadData1(rd1_nb), .ReadData2(rd2_nb), .ReadBusy1(b1_nb), .ReadBusy2(b2_nb),
        .WriteRegister(wa), .WriteData(wd), .RegWrite(we),
        .ReserveRegister(ra), .ReserveEn(re), .BusyCount(cnt_nb), .AllOutputs(all_nb));

    regfile_sb_param #(.WIDTH(16), .DEPTH(16), .GP_IDX(12), .SP_IDX(13)) dut16 (
        .Clk(clk), .Reset(rst), .ReadRegister1(r1_16), .ReadRegister2(r2_16),
        .ReadData1(rd1_16), .ReadData2(rd2_16), .ReadBusy1(b1_16), .ReadBusy2(b2_16),
        .WriteRegister(wa16), .WriteData(wd16), .RegWrite(we16),
        .ReserveRegister(ra16), .ReserveEn(re16), .BusyCount(cnt16), .AllOutputs(all16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model update: architectural state after each edge, including async reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  <= (i == 28) ? 32'h0000_1800 : ((i == 29) ? 32'h0000_3ffc : 32'h0);
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (we && wa != 5'd0) begin
                m_reg[wa]  <= wd;
                m_busy[wa] <= 1'b0;
            end
            if (re && ra != 5'd0) begin
                m_busy[ra] <= 1'b1;
            end
        end
    end

    function automatic int busy_total();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (byp && we && wa == a && a != 5'd0) return wd;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (byp && we && wa == a && a != 5'd0) return 1'b0;
        return m_busy[a];
    endfunction

    // Compare process: both 32-entry instances against the model on every cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 32; i++) begin
            chk("snap_byp", 64'(all_o[i*32 +: 32]), 64'(m_reg[i]));
            chk("snap_nob", 64'(all_nb[i*32 +: 32]), 64'(m_reg[i]));
        end
        chk("cnt_byp", 64'(cnt), 64'(busy_total()));
        chk("cnt_nob", 64'(cnt_nb), 64'(busy_total()));
        if (!rst) begin
            chk("rd1_byp",  64'(rd1),    64'(exp_data(r1, 1'b1)));
            chk("rd2_byp",  64'(rd2),    64'(exp_data(r2, 1'b1)));
            chk("b1_byp",   64'(b1),     64'(exp_busy(r1, 1'b1)));
            chk("b2_byp",   64'(b2),     64'(exp_busy(r2, 1'b1)));
            chk("rd1_nob",  64'(rd1_nb), 64'(exp_data(r1, 1'b0)));
            chk("rd2_nob",  64'(rd2_nb), 64'(exp_data(r2, 1'b0)));
            chk("b1_nob",   64'(b1_nb),  64'(exp_busy(r1, 1'b0)));
            chk("b2_nob",   64'(b2_nb),  64'(exp_busy(r2, 1'b0)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [4:0] a1, input logic [4:0] a2,
                       input logic w, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic rv, input logic [4:0] raddr);
        r1 = a1; r2 = a2; we = w; wa = waddr; wd = wdata; re = rv; ra = raddr;
    endtask

    initial begin
        rst = 1'b1;
        put(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        r1_16 = 4'd0; r2_16 = 4'd0; we16 = 1'b0; wa16 = 4'd0; wd16 = 16'h0;
        re16 = 1'b0; ra16 = 4'd0;
        tick(); tick();
        rst = 1'b0;

        // Reset presets.
        put(5'd28, 5'd29, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_gp", 64'(rd1), 64'h1800);
        chk("lit_sp", 64'(rd2), 64'h3ffc);
        chk("lit_cnt0", 64'(cnt), 64'd0);
        tick();

        // Register 0 is immune to writes, even through the bypass path.
        put(5'd0, 5'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_r0_byp", 64'(rd1), 64'h0);
        tick();
        put(5'd0, 5'd5, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_r0", 64'(rd1), 64'h0);
        chk("lit_r5_fwd", 64'(rd2), 64'h1234_5678);
        chk("lit_r5_old", 64'(rd2_nb), 64'h0);
        tick();
        put(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_r5_nb", 64'(rd1_nb), 64'h1234_5678);
        tick();

        // Same-cycle forwarding, compared with and without bypass.
        put(5'd7, 5'd7, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_r7_fwd", 64'(rd1), 64'hA5A5_A5A5);
        chk("lit_r7_old", 64'(rd1_nb), 64'h0);
        tick();
        put(5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_r7_new", 64'(rd1_nb), 64'hA5A5_A5A5);
        tick();

        // Scoreboard: reserve r3 and r9, then retire them with writes.
        put(5'd3, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
        tick();
        put(5'd3, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        @(negedge clk);
        chk("lit_b3", 64'(b1), 64'd1);
        chk("lit_b9_late", 64'(b2), 64'd0);
        tick();
        put(5'd3, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_b9", 64'(b2), 64'd1);
        chk("lit_cnt2", 64'(cnt), 64'd2);
        tick();
        put(5'd3, 5'd9, 1'b1, 5'd3, 32'h3333_3333, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_b3_fwd", 64'(b1), 64'd0);
        chk("lit_b3_nob", 64'(b1_nb), 64'd1);
        tick();
        put(5'd3, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_cnt1", 64'(cnt), 64'd1);
        tick();
        put(5'd3, 5'd9, 1'b1, 5'd9, 32'h9999_9999, 1'b1, 5'd3);
        tick();
        put(5'd3, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_swap_cnt", 64'(cnt), 64'd1);
        chk("lit_swap_b3", 64'(b1), 64'd1);
        chk("lit_swap_b9", 64'(b2), 64'd0);
        tick();

        // Write and reserve of the same register in one cycle: busy stays set.
        put(5'd4, 5'd4, 1'b1, 5'd4, 32'h0BAD_F00D, 1'b1, 5'd4);
        tick();
        put(5'd4, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_r4", 64'(rd1), 64'h0BAD_F00D);
        chk("lit_b4", 64'(b1), 64'd1);
        chk("lit_cnt_wr_rsv", 64'(cnt), 64'd2);
        tick();
        put(5'd4, 5'd5, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
        tick();
        put(5'd4, 5'd5, 1'b1, 5'd5, 32'h5555_5555, 1'b1, 5'd0);
        tick();
        put(5'd0, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_cnt_hold", 64'(cnt), 64'd2);
        chk("lit_r0_busy", 64'(b1), 64'd0);
        chk("lit_r5_wr", 64'(rd2), 64'h5555_5555);
        tick();

        // Mixed traffic: the model compare covers every cycle.
        for (int i = 0; i < 24; i++) begin
            put(5'((i * 3) % 32), 5'((i * 11) % 32), (i % 3) != 2, 5'((i * 7) % 32),
                (32'(i) * 32'h0101_0101) ^ 32'hF0F0_F0F0, (i % 2) == 0, 5'((i * 5) % 32));
            tick();
        end

        // Asynchronous reset in the middle of a write and a reserve.
        put(5'd6, 5'd10, 1'b1, 5'd6, 32'h6666_6666, 1'b1, 5'd10);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("lit_rst_cnt", 64'(cnt), 64'd0);
        tick();
        rst = 1'b0;
        put(5'd6, 5'd28, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_rst_r6", 64'(rd1), 64'h0);
        chk("lit_rst_gp", 64'(rd2), 64'h1800);
        tick();
        put(5'd10, 5'd29, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        chk("lit_rst_b10", 64'(b1), 64'd0);
        chk("lit_rst_sp", 64'(rd2), 64'h3ffc);
        tick();

        // 16x16 instance: presets, then fill and drain the whole scoreboard.
        r1_16 = 4'd12; r2_16 = 4'd13;
        @(negedge clk);
        chk("lit16_gp", 64'(rd1_16), 64'h1800);
        chk("lit16_sp", 64'(rd2_16), 64'h3ffc);
        re16 = 1'b1; ra16 = 4'd0;
        tick();
        @(negedge clk);
        chk("lit16_r0_rsv", 64'(cnt16), 64'd0);
        for (int i = 1; i < 16; i++) begin
            ra16 = 4'(i);
            tick();
            @(negedge clk);
            chk("lit16_fill", 64'(cnt16), 64'(i));
        end
        re16 = 1'b0;
        r1_16 = 4'd15; r2_16 = 4'd1;
        @(negedge clk);
        chk("lit16_full", 64'(cnt16), 64'd15);
        chk("lit16_b15", 64'(b1_16), 64'd1);
        chk("lit16_b1", 64'(b2_16), 64'd1);
        we16 = 1'b1;
        for (int i = 1; i < 16; i++) begin
            wa16 = 4'(i);
            wd16 = 16'(i) * 16'h0111;
            tick();
            @(negedge clk);
            chk("lit16_drain", 64'(cnt16), 64'(15 - i));
        end
        we16 = 1'b0;
        tick();
        @(negedge clk);
        chk("lit16_b1_clr", 64'(b2_16), 64'd0);
        for (int i = 0; i < 16; i++) begin
            chk("lit16_snap", 64'(all16[i*16 +: 16]), 64'(i * 16'h0111));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
